// File: rtl/letc_core_store_buffer_if.sv
// letc_core_store_buffer_if: store-buffer signal bundle (request, commit, memory write bus, load probe)
//   slave  modport: the store buffer's view of these signals
//   master modport: the core/memory-side view of these signals (drives requests, commits, bus_ready, load probes)
interface letc_core_store_buffer_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        commit;
    logic [31:0] commit_data;
    logic        flush;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        ld_check_valid;
    logic [31:0] ld_check_addr;
    logic        ld_conflict;
    logic        ld_fwd_hit;
    logic [31:0] ld_fwd_data;
    logic        empty;

    modport slave (
        input  req_valid, req_addr, commit, commit_data, flush, bus_ready, ld_check_valid, ld_check_addr,
        output req_ready, bus_valid, bus_addr, bus_wdata, ld_conflict, ld_fwd_hit, ld_fwd_data, empty
    );

    modport master (
        output req_valid, req_addr, commit, commit_data, flush, bus_ready, ld_check_valid, ld_check_addr,
        input  req_ready, bus_valid, bus_addr, bus_wdata, ld_conflict, ld_fwd_hit, ld_fwd_data, empty
    );
endinterface

// File: rtl/letc_core_store_buffer.sv
// letc_core_store_buffer: one pending (address-only) store plus a DEPTH-entry committed FIFO draining to memory
//   clk, rst_n : clock, synchronous active-low reset
//   sb (slave) : req_* address phase, commit/commit_data/flush from writeback,
//                bus_* memory write port, ld_check_* probe with ld_conflict/ld_fwd_hit/ld_fwd_data, empty
//   Define LETC_SB_LOAD_FWD_EN to forward committed store data to loads instead of stalling them.
module letc_core_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    letc_core_store_buffer_if.slave      sb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          pending_valid;
    logic [29:0]   pending_addr;
    logic [29:0]   fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          accept, push, pop;
    logic          pend_hit, cm_hit;
    logic [31:0]   cm_data;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{sb.req_addr[1:0], sb.ld_check_addr[1:0]};

    assign sb.req_ready = !pending_valid && (count < CW'(DEPTH));
    assign accept       = sb.req_valid && sb.req_ready;
    assign push         = sb.commit && pending_valid;
    assign pop          = sb.bus_valid && sb.bus_ready;

    assign sb.bus_valid = count != '0;
    assign sb.bus_addr  = {fifo_addr[rd_ptr], 2'b00};
    assign sb.bus_wdata = fifo_data[rd_ptr];
    assign sb.empty     = !pending_valid && count == '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_valid <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            // accept only happens with no pending entry; commit (push) wins over flush, both clear it
            pending_valid <= accept || (pending_valid && !sb.commit && !sb.flush);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) pending_addr <= sb.req_addr[31:2];
        if (push) begin
            fifo_addr[wr_ptr] <= pending_addr;
            fifo_data[wr_ptr] <= sb.commit_data;
        end
    end

    assign pend_hit = pending_valid && pending_addr == sb.ld_check_addr[31:2];

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        cm_hit  = 1'b0;
        cm_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count && fifo_addr[rd_ptr + AW'(k)] == sb.ld_check_addr[31:2]) begin
                cm_hit = 1'b1;
`ifdef LETC_SB_LOAD_FWD_EN
                cm_data = fifo_data[rd_ptr + AW'(k)];
`endif
            end
        end
    end

`ifdef LETC_SB_LOAD_FWD_EN
    assign sb.ld_conflict = sb.ld_check_valid && pend_hit;
    assign sb.ld_fwd_hit  = sb.ld_check_valid && !pend_hit && cm_hit;
    assign sb.ld_fwd_data = sb.ld_fwd_hit ? cm_data : '0;
`else
    assign sb.ld_conflict = sb.ld_check_valid && (pend_hit || cm_hit);
    assign sb.ld_fwd_hit  = 1'b0;
    assign sb.ld_fwd_data = '0;
`endif
endmodule

// File: doc/letc_core_store_buffer.md
LETC_CORE_STORE_BUFFER -- requirements
Module: letc_core_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: committed-store FIFO entries; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  clock; every state element updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  store request from dmss1; address phase.
REQ-005 SHALL have port req_addr  input  32  store byte address; bits [1:0] ignored, word-granular.
REQ-006 SHALL have port req_ready  output  1  a store request is accepted this cycle.
REQ-007 SHALL have port commit  input  1  writeback commit of the pending store.
REQ-008 SHALL have port commit_data  input  32  fully merged store word from writeback.
REQ-009 SHALL have port flush  input  1  discard the pending, uncommitted store.
REQ-010 SHALL have port bus_valid  output  1  memory write request valid.
REQ-011 SHALL have port bus_addr  output  32  write word address, bits [1:0] = 0.
REQ-012 SHALL have port bus_wdata  output  32  write data.
REQ-013 SHALL have port bus_ready  input  1  memory accepts the write.
REQ-014 SHALL have port ld_check_valid  input  1  a load is probing the buffer.
REQ-015 SHALL have port ld_check_addr  input  32  load address; compared on bits [31:2].
REQ-016 SHALL have port ld_conflict  output  1  the load must stall.
REQ-017 SHALL have port ld_fwd_hit  output  1  forwarded data is valid.
REQ-018 SHALL have port ld_fwd_data  output  32  forwarded store word.
REQ-019 SHALL have port empty  output  1  no pending and no committed entries.

Function
REQ-020 SHALL hold at most one pending entry (address only) and DEPTH committed entries (address+data) in FIFO order.
REQ-021 SHALL drive req_ready = !pending_valid && (committed_count < DEPTH); it SHALL NOT account for a same-cycle commit or pop.
REQ-022 SHALL capture req_addr[31:2] into the pending entry on req_valid && req_ready.
REQ-023 SHALL, on commit with a pending entry present, push {pending addr, commit_data} to the FIFO tail and clear pending; the entry is visible on the bus the next cycle.
REQ-024 SHALL ignore a commit with no pending entry, leaving all state unchanged.
REQ-025 SHALL, on flush without commit, clear the pending entry; committed entries are unaffected.
REQ-026 SHALL give commit precedence when commit and flush coincide; flush is ignored that cycle.
REQ-027 SHALL drive bus_valid = FIFO non-empty, with bus_addr/bus_wdata taken from the FIFO head; the head SHALL remain stable until bus_ready.
REQ-028 SHALL pop the head on bus_valid && bus_ready; a same-cycle push and pop SHALL leave the count unchanged.
REQ-029 SHALL wrap read/write pointers modulo DEPTH; count is kept in $clog2(DEPTH)+1 bits.
REQ-030 SHALL compute ld_conflict, ld_fwd_hit and ld_fwd_data combinationally from the current state; they are zero when ld_check_valid = 0.
REQ-031 SHALL drive empty = !pending_valid && count == 0.

Reset
REQ-032 SHALL, on reset, clear pending_valid, pointers and count; outputs SHALL be req_ready = 1, bus_valid = 0, ld_conflict = 0, ld_fwd_hit = 0, empty = 1.
REQ-033 SHALL discard all entries on reset mid-operation, including any head awaiting bus_ready.
REQ-034 SHALL leave data and address storage unreset.

Configuration
REQ-035 SHALL compile store-to-load forwarding only when LETC_SB_LOAD_FWD_EN is defined.
REQ-036 Without the macro: ld_conflict = any valid pending or committed entry matches [31:2]; ld_fwd_hit = 0 and ld_fwd_data = 0.
REQ-037 With the macro: ld_conflict = pending entry matches; otherwise, if any committed entry matches, ld_fwd_hit = 1 and ld_fwd_data = data of the youngest matching entry.

Verification
REQ-038 SHALL cover: req 0x1000, commit 0xAABBCCDD, bus_ready = 1 -> bus_valid the cycle after commit with addr 0x1000 and data 0xAABBCCDD, then empty = 1.
REQ-039 SHALL cover: bus_ready = 0, four req+commit pairs -> req_ready = 0; one bus_ready pulse pops the oldest entry and req_ready returns to 1.
REQ-040 SHALL cover: req 0x2004, then flush -> no bus write and empty = 1; req then commit+flush in the same cycle -> entry written.
REQ-041 SHALL cover: commit with no pending entry -> no state change and bus_valid stays 0.
REQ-042 SHALL cover: committed stores 0x3000 = 0x11 then 0x3000 = 0x22, load probe 0x3002 -> without the macro ld_conflict = 1; with the macro ld_fwd_hit = 1 and ld_fwd_data = 0x22.
REQ-043 SHALL cover: rst_n low with 3 entries and bus stalled -> next cycle bus_valid = 0 and empty = 1.
